// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: issues word-aligned req/ack accesses, builds store
// lanes and byte enables, formats load data, and stalls the pipeline while an access is open.
module mem_access_unit #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] EX_MEM_ALUResult,
    input  logic [31:0] EX_MEM_WriteData,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic [1:0]  EX_MEM_MemSize,
    input  logic        EX_MEM_LoadSigned,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    output logic [3:0]  Mem_BE,
    input  logic [31:0] Mem_RData,
    input  logic        Mem_Ack,
    output logic [31:0] LoadMux,
    output logic        MemStall,
    output logic        MisalignExc,
    output logic        BusErr
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic [1:0]       r_off;
    logic [1:0]       r_size;
    logic             r_signed;
    logic             r_load;
    logic             r_bus_err;

    logic             w_access;
    logic             w_is_half;
    logic             w_is_byte;
    logic             w_misalign;
    logic             w_issue;
    logic             w_ack_hit;
    logic             w_timeout;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [7:0]       w_ld_byte;
    logic [15:0]      w_ld_half;

    assign w_access   = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign w_is_half  = (EX_MEM_MemSize == SZ_HALF);
    assign w_is_byte  = (EX_MEM_MemSize == SZ_BYTE);
    // Size 2'b11 falls into the word case along with 2'b00.
    assign w_misalign = (w_is_half & EX_MEM_ALUResult[0]) |
                        (~w_is_half & ~w_is_byte & (EX_MEM_ALUResult[1:0] != 2'b00));

    assign w_issue   = (r_state == S_IDLE) & w_access & ~w_misalign;
    assign w_ack_hit = (r_state == S_BUSY) & Mem_Ack;
    assign w_timeout = (r_state == S_BUSY) & ~Mem_Ack & (r_cnt == LAST_CNT);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_be    = 4'b0000;
        w_wdata = EX_MEM_WriteData;
        case (EX_MEM_MemSize)
            SZ_BYTE: begin
                w_be    = 4'b0001 << EX_MEM_ALUResult[1:0];
                w_wdata = {4{EX_MEM_WriteData[7:0]}};
            end
            SZ_HALF: begin
                w_be    = EX_MEM_ALUResult[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{EX_MEM_WriteData[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = EX_MEM_WriteData;
            end
        endcase
        // Loads never drive byte enables.
        if (!EX_MEM_MemWrite) begin
            w_be = 4'b0000;
        end
    end

    always_comb begin
        w_next      = r_state;
        MemStall    = 1'b0;
        MisalignExc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (w_misalign) begin
                        MisalignExc = 1'b1;
                    end else begin
                        MemStall = 1'b1;
                        w_next   = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                MemStall = 1'b1;
                if (Mem_Ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // The stall must fall with reset even while EX_MEM still holds an access.
        if (Rst) begin
            MemStall = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            Mem_Req   <= 1'b0;
            Mem_We    <= 1'b0;
            Mem_Addr  <= '0;
            Mem_WData <= '0;
            Mem_BE    <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_off     <= '0;
            r_size    <= '0;
            r_signed  <= 1'b0;
            r_load    <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_bus_err <= w_timeout;
            if (w_issue) begin
                Mem_Req   <= 1'b1;
                Mem_We    <= EX_MEM_MemWrite;
                Mem_Addr  <= {EX_MEM_ALUResult[31:2], 2'b00};
                Mem_BE    <= w_be;
                Mem_WData <= w_wdata;
                r_off     <= EX_MEM_ALUResult[1:0];
                r_size    <= EX_MEM_MemSize;
                r_signed  <= EX_MEM_LoadSigned;
                r_load    <= EX_MEM_MemRead;
                r_cnt     <= '0;
            end else if (w_ack_hit) begin
                Mem_Req <= 1'b0;
                Mem_We  <= 1'b0;
                Mem_BE  <= 4'b0000;
                r_rdata <= Mem_RData;
            end else if (w_timeout) begin
                Mem_Req <= 1'b0;
                Mem_We  <= 1'b0;
                Mem_BE  <= 4'b0000;
                r_rdata <= '0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_ld_byte = r_rdata[7:0];
        case (r_off)
            2'd1:    w_ld_byte = r_rdata[15:8];
            2'd2:    w_ld_byte = r_rdata[23:16];
            2'd3:    w_ld_byte = r_rdata[31:24];
            default: w_ld_byte = r_rdata[7:0];
        endcase
    end

    assign w_ld_half = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];

    always_comb begin
        LoadMux = '0;
        if ((r_state == S_DONE) && r_load) begin
            case (r_size)
                SZ_BYTE: LoadMux = {{24{r_signed & w_ld_byte[7]}}, w_ld_byte};
                SZ_HALF: LoadMux = {{16{r_signed & w_ld_half[15]}}, w_ld_half};
                default: LoadMux = r_rdata;
            endcase
        end
    end

    assign BusErr = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, ack timeout,
// reset abort and back-to-back accesses, checked against hand-computed values.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] EX_MEM_ALUResult;
    logic [31:0] EX_MEM_WriteData;
    logic        EX_MEM_MemRead;
    logic        EX_MEM_MemWrite;
    logic [1:0]  EX_MEM_MemSize;
    logic        EX_MEM_LoadSigned;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [3:0]  Mem_BE;
    logic [31:0] Mem_RData;
    logic        Mem_Ack;
    logic [31:0] LoadMux;
    logic        MemStall;
    logic        MisalignExc;
    logic        BusErr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.ACK_TIMEOUT(4)) dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .EX_MEM_ALUResult  (EX_MEM_ALUResult),
        .EX_MEM_WriteData  (EX_MEM_WriteData),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_MemWrite   (EX_MEM_MemWrite),
        .EX_MEM_MemSize    (EX_MEM_MemSize),
        .EX_MEM_LoadSigned (EX_MEM_LoadSigned),
        .Mem_Req           (Mem_Req),
        .Mem_We            (Mem_We),
        .Mem_Addr          (Mem_Addr),
        .Mem_WData         (Mem_WData),
        .Mem_BE            (Mem_BE),
        .Mem_RData         (Mem_RData),
        .Mem_Ack           (Mem_Ack),
        .LoadMux           (LoadMux),
        .MemStall          (MemStall),
        .MisalignExc       (MisalignExc),
        .BusErr            (BusErr)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge; inputs change here, outputs are sampled 1 ns later.
    task automatic fall();
        @(negedge Clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        EX_MEM_MemRead    = 1'b0;
        EX_MEM_MemWrite   = 1'b0;
        EX_MEM_MemSize    = 2'b00;
        EX_MEM_LoadSigned = 1'b0;
        EX_MEM_ALUResult  = 32'h0;
        EX_MEM_WriteData  = 32'h0;
        Mem_Ack           = 1'b0;
        Mem_RData         = 32'h0;
    endtask

    initial begin
        Rst = 1'b1;
        idle_inputs();

        // Reset state
        fall(); settle();
        check("rst_req",   {31'b0, Mem_Req},  32'h0);
        check("rst_we",    {31'b0, Mem_We},   32'h0);
        check("rst_addr",  Mem_Addr,          32'h0);
        check("rst_wdata", Mem_WData,         32'h0);
        check("rst_be",    {28'b0, Mem_BE},   32'h0);
        check("rst_load",  LoadMux,           32'h0);
        check("rst_stall", {31'b0, MemStall}, 32'h0);
        check("rst_buserr",{31'b0, BusErr},   32'h0);
        fall(); Rst = 1'b0;
        fall();

        // 1: signed byte load at 0x103, ack in first BUSY cycle
        EX_MEM_MemRead = 1'b1; EX_MEM_ALUResult = 32'h103;
        EX_MEM_MemSize = 2'b10; EX_MEM_LoadSigned = 1'b1;
        settle();
        check("t1_stall_idle", {31'b0, MemStall},    32'h1);
        check("t1_misalign",   {31'b0, MisalignExc}, 32'h0);
        check("t1_req_idle",   {31'b0, Mem_Req},     32'h0);
        fall(); Mem_Ack = 1'b1; Mem_RData = 32'h80FF_FF00; settle();
        check("t1_req_busy",   {31'b0, Mem_Req},  32'h1);
        check("t1_we",         {31'b0, Mem_We},   32'h0);
        check("t1_addr",       Mem_Addr,          32'h100);
        check("t1_be",         {28'b0, Mem_BE},   32'h0);
        check("t1_stall_busy", {31'b0, MemStall}, 32'h1);
        fall(); Mem_Ack = 1'b0; Mem_RData = 32'h0; settle();
        check("t1_stall_done", {31'b0, MemStall}, 32'h0);
        check("t1_loadmux",    LoadMux,           32'hFFFF_FF80);
        check("t1_req_done",   {31'b0, Mem_Req},  32'h0);
        check("t1_buserr",     {31'b0, BusErr},   32'h0);
        fall(); idle_inputs(); settle();
        check("t1_load_after", LoadMux,           32'h0);
        check("t1_stall_after",{31'b0, MemStall}, 32'h0);

        // 2: half store at 0x202, ack on third BUSY cycle
        fall();
        EX_MEM_MemWrite = 1'b1; EX_MEM_ALUResult = 32'h202;
        EX_MEM_WriteData = 32'h1234_ABCD; EX_MEM_MemSize = 2'b01;
        settle();
        check("t2_stall_idle", {31'b0, MemStall}, 32'h1);
        fall(); settle();
        check("t2_req",   {31'b0, Mem_Req},  32'h1);
        check("t2_we",    {31'b0, Mem_We},   32'h1);
        check("t2_be",    {28'b0, Mem_BE},   32'hC);
        check("t2_wdata", Mem_WData,         32'hABCD_ABCD);
        check("t2_addr",  Mem_Addr,          32'h200);
        check("t2_stall_b1", {31'b0, MemStall}, 32'h1);
        fall(); settle();
        check("t2_stall_b2", {31'b0, MemStall}, 32'h1);
        fall(); Mem_Ack = 1'b1; settle();
        check("t2_stall_b3", {31'b0, MemStall}, 32'h1);
        fall(); Mem_Ack = 1'b0; settle();
        check("t2_stall_done", {31'b0, MemStall}, 32'h0);
        check("t2_loadmux",    LoadMux,           32'h0);
        check("t2_req_done",   {31'b0, Mem_Req},  32'h0);
        check("t2_we_done",    {31'b0, Mem_We},   32'h0);
        check("t2_be_done",    {28'b0, Mem_BE},   32'h0);
        fall(); idle_inputs();

        // Byte store at 0x601: lane 1 enable, replicated data
        EX_MEM_MemWrite = 1'b1; EX_MEM_ALUResult = 32'h601;
        EX_MEM_WriteData = 32'h0000_00A5; EX_MEM_MemSize = 2'b10;
        fall(); Mem_Ack = 1'b1; settle();
        check("sb_be",    {28'b0, Mem_BE}, 32'h2);
        check("sb_wdata", Mem_WData,       32'hA5A5_A5A5);
        fall(); Mem_Ack = 1'b0;
        fall(); idle_inputs();

        // 3: misaligned word load at 0x301
        EX_MEM_MemRead = 1'b1; EX_MEM_ALUResult = 32'h301; EX_MEM_MemSize = 2'b00;
        settle();
        check("t3_misalign", {31'b0, MisalignExc}, 32'h1);
        check("t3_stall",    {31'b0, MemStall},    32'h0);
        check("t3_loadmux",  LoadMux,              32'h0);
        fall(); settle();
        check("t3_req",      {31'b0, Mem_Req},     32'h0);
        check("t3_misalign2",{31'b0, MisalignExc}, 32'h1);
        fall(); idle_inputs();

        // 4: word load at 0x400 with no ack -> timeout after 4 BUSY cycles
        EX_MEM_MemRead = 1'b1; EX_MEM_ALUResult = 32'h400; EX_MEM_MemSize = 2'b00;
        Mem_RData = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            fall(); settle();
            check($sformatf("t4_req_b%0d", c),   {31'b0, Mem_Req},  32'h1);
            check($sformatf("t4_stall_b%0d", c), {31'b0, MemStall}, 32'h1);
        end
        fall(); settle();
        check("t4_req_done",   {31'b0, Mem_Req},  32'h0);
        check("t4_buserr",     {31'b0, BusErr},   32'h1);
        check("t4_loadmux",    LoadMux,           32'h0);
        check("t4_stall_done", {31'b0, MemStall}, 32'h0);
        fall(); idle_inputs(); settle();
        check("t4_buserr_clr", {31'b0, BusErr},   32'h0);

        // 5: reset asserted mid-BUSY aborts without a clock edge
        fall();
        EX_MEM_MemRead = 1'b1; EX_MEM_ALUResult = 32'h500; EX_MEM_MemSize = 2'b00;
        fall(); settle();
        check("t5_req_busy", {31'b0, Mem_Req}, 32'h1);
        #2 Rst = 1'b1;
        #1;
        check("t5_req_rst",   {31'b0, Mem_Req},  32'h0);
        check("t5_stall_rst", {31'b0, MemStall}, 32'h0);
        fall(); idle_inputs(); Rst = 1'b0; settle();
        check("t5_stall_rel", {31'b0, MemStall}, 32'h0);
        fall(); Mem_Ack = 1'b1; Mem_RData = 32'h1122_3344; settle();
        check("t5_req_ack",   {31'b0, Mem_Req},  32'h0);
        fall(); Mem_Ack = 1'b0; settle();
        check("t5_no_done",   LoadMux,           32'h0);
        check("t5_no_buserr", {31'b0, BusErr},   32'h0);
        fall(); idle_inputs();

        // 6: back-to-back loads, unsigned half at 0x002 then word at 0x004
        EX_MEM_MemRead = 1'b1; EX_MEM_ALUResult = 32'h002;
        EX_MEM_MemSize = 2'b01; EX_MEM_LoadSigned = 1'b0;
        settle();
        check("t6_stall_i1", {31'b0, MemStall}, 32'h1);
        fall(); Mem_Ack = 1'b1; Mem_RData = 32'hBEEF_1234; settle();
        check("t6_addr1", Mem_Addr, 32'h0);
        fall(); Mem_Ack = 1'b0; Mem_RData = 32'h0; settle();
        check("t6_load1",       LoadMux,           32'h0000_BEEF);
        check("t6_stall_done1", {31'b0, MemStall}, 32'h0);
        EX_MEM_ALUResult = 32'h004; EX_MEM_MemSize = 2'b00;
        fall(); settle();
        check("t6_stall_i2", {31'b0, MemStall}, 32'h1);
        check("t6_idle_load",LoadMux,           32'h0);
        fall(); Mem_Ack = 1'b1; Mem_RData = 32'hCAFE_F00D; settle();
        check("t6_addr2", Mem_Addr, 32'h4);
        fall(); Mem_Ack = 1'b0; Mem_RData = 32'h0; settle();
        check("t6_load2",       LoadMux,           32'hCAFE_F00D);
        check("t6_stall_done2", {31'b0, MemStall}, 32'h0);
        fall(); idle_inputs(); settle();
        check("t6_load_after", LoadMux, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
